// File: rtl/spi_bitstream_loader.sv
// spi_bitstream_loader
//   SPI-mode-0 initiator that reads the FPGA configuration image out of an
//   external NOR flash. One READ (0x03) command with a 24-bit start address is
//   issued, then a 32-bit length header N is read, then N payload words, which
//   are handed to the configuration logic over a valid/ready interface.
//   Backpressure on that interface freezes SCLK, so no bit is lost.
//
// Parameters
//   CLK_DIV    : SCLK half-period in clk cycles (>= 1)
//   START_ADDR : flash byte address of the length header
//   MAX_WORDS  : largest legal payload word count
//
// Ports
//   clk, rst                  : system clock, synchronous active-high reset
//   start_i                   : one-cycle pulse, starts a load from IDLE/DONE
//   spi_csb_o/sclk_o/mosi_o   : flash chip select (active low), clock, data out
//   spi_miso_i                : flash data in, MSB first
//   word_o/word_valid_o       : payload word and its valid flag
//   word_ready_i              : consumer accepts word_o when high with valid
//   busy_o, done_o, error_o   : load in progress / finished / bad header
module spi_bitstream_loader #(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [23:0] START_ADDR = 24'h000000,
  parameter int unsigned MAX_WORDS  = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  output logic        spi_csb_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [31:0] CMD_WORD = {8'h03, START_ADDR};

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_HDR, S_DATA, S_DONE} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [30:0]   tx_sr;    // command/address bits still to be sent after the current MOSI bit
  logic [31:0]   rx_sr;
  logic          rx_full;  // rx_sr holds a complete 32-bit value not yet consumed
  logic [31:0]   rx_left;  // payload words still to be shifted in

  logic div_tick, rise_blk, accept, rx_phase;

  always_comb begin
    div_tick = (div_cnt == DW'(CLK_DIV - 1));
    rx_phase = (state == S_HDR) || (state == S_DATA);
    // A rising edge would sample into a full shift register, or past the last word.
    rise_blk = rx_full || ((state == S_DATA) && (rx_left == '0));
    accept   = word_valid_o && word_ready_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      rx_full      <= 1'b0;
      rx_left      <= '0;
      spi_csb_o    <= 1'b1;
      spi_sclk_o   <= 1'b0;
      spi_mosi_o   <= 1'b0;
      word_o       <= '0;
      word_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state        <= S_CMD;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            spi_csb_o    <= 1'b0;
            spi_sclk_o   <= 1'b0;
            spi_mosi_o   <= CMD_WORD[31];
            tx_sr        <= CMD_WORD[30:0];
            div_cnt      <= '0;
            bit_cnt      <= '0;
            rx_full      <= 1'b0;
            word_valid_o <= 1'b0;
          end
        end
        default: begin
          // SCLK generator: the high phase always completes; the low phase is
          // frozen while a rising edge is blocked.
          if (spi_sclk_o || !rise_blk) begin
            if (div_tick) begin
              div_cnt    <= '0;
              spi_sclk_o <= ~spi_sclk_o;
              if (!spi_sclk_o) begin
                bit_cnt <= bit_cnt + 5'd1;
                if (rx_phase) rx_sr <= {rx_sr[30:0], spi_miso_i};
                if ((state == S_CMD) && (bit_cnt == 5'd7)) state <= S_ADDR;
                if ((state == S_ADDR) && (bit_cnt == 5'd31)) state <= S_HDR;
                if (rx_phase && (bit_cnt == 5'd31)) rx_full <= 1'b1;
                if ((state == S_DATA) && (bit_cnt == 5'd31)) rx_left <= rx_left - 32'd1;
              end else begin
                spi_mosi_o <= tx_sr[30];
                tx_sr      <= {tx_sr[29:0], 1'b0};
              end
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
          end

          // Header check one cycle after its last bit; later assignments win
          // over the SCLK generator so the bus is parked cleanly.
          if ((state == S_HDR) && rx_full) begin
            rx_full <= 1'b0;
            if ((rx_sr == '0) || (rx_sr > 32'(MAX_WORDS))) begin
              state      <= S_DONE;
              spi_csb_o  <= 1'b1;
              spi_sclk_o <= 1'b0;
              spi_mosi_o <= 1'b0;
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
              error_o    <= 1'b1;
            end else begin
              state   <= S_DATA;
              rx_left <= rx_sr;
            end
          end

          if (state == S_DATA) begin
            if (rx_full && (!word_valid_o || word_ready_i)) begin
              word_o       <= rx_sr;
              word_valid_o <= 1'b1;
              rx_full      <= 1'b0;
            end else if (accept) begin
              word_valid_o <= 1'b0;
              if (!rx_full && (rx_left == '0)) begin
                state      <= S_DONE;
                spi_csb_o  <= 1'b1;
                spi_sclk_o <= 1'b0;
                spi_mosi_o <= 1'b0;
                busy_o     <= 1'b0;
                done_o     <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bitstream_loader.sv
// Bench for spi_bitstream_loader: two instances (CLK_DIV=2 at address 0,
// CLK_DIV=1 at address 0x100000) each attached to a behavioural SPI flash
// that serves a word image. Expected words are queued at launch and popped
// by a monitor on every handshake.
module tb_spi_bitstream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [1:0]  start_s, csb, sclk, mosi, miso, valid, busy, done, err;
  logic [31:0] word [2];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic [31:0] img[$];     // flash contents from START_ADDR: header then payload
  logic [31:0] exp_q[$];   // words the consumer must receive, in order

  int          rises [2];
  logic [31:0] cmd_addr [2];
  int          mosi_bad [2];
  int          csb_bad [2];
  int unsigned rise64_cyc [2];

  int          ready_mode;  // 0: always ready, 1: random, 2: never ready
  bit          thru_en;
  bit          have_prev;
  int unsigned prev_acc, last_acc_cyc;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  function automatic int cd_of(int g);
    return (g == 0) ? 2 : 1;
  endfunction

  function automatic logic [23:0] addr_of(int g);
    return (g == 0) ? 24'h000000 : 24'h100000;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = ($urandom_range(3) != 0);
      default: ready = 1'b0;
    endcase
  end

  for (genvar g = 0; g < 2; g++) begin : inst
    spi_bitstream_loader #(
      .CLK_DIV   ((g == 0) ? 2 : 1),
      .START_ADDR((g == 0) ? 24'h000000 : 24'h100000),
      .MAX_WORDS (65535)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_s[g]),
      .spi_csb_o   (csb[g]),
      .spi_sclk_o  (sclk[g]),
      .spi_mosi_o  (mosi[g]),
      .spi_miso_i  (miso[g]),
      .word_o      (word[g]),
      .word_valid_o(valid[g]),
      .word_ready_i(ready),
      .busy_o      (busy[g]),
      .done_o      (done[g]),
      .error_o     (err[g])
    );

    // Flash: new transaction on CS fall.
    initial forever begin
      @(negedge csb[g]);
      rises[g]    = 0;
      cmd_addr[g] = '0;
      mosi_bad[g] = 0;
      miso[g]     = 1'b0;
    end

    // Flash: first 32 rising edges capture command + address, later ones expect MOSI=0.
    initial forever begin
      @(posedge sclk[g]);
      if (csb[g] === 1'b0) begin
        if (rises[g] < 32) cmd_addr[g] = {cmd_addr[g][30:0], mosi[g]};
        else if (mosi[g] !== 1'b0) mosi_bad[g]++;
        rises[g]++;
        if (rises[g] == 64) rise64_cyc[g] = cyc;
      end
    end

    // Flash: shift out image bit (rises-32) after each falling edge, MSB first.
    initial forever begin
      @(negedge sclk[g]);
      if (csb[g] === 1'b0 && rises[g] >= 32) begin
        int unsigned idx;
        logic [31:0] w;
        idx = rises[g] - 32;
        w = (idx / 32 < img.size()) ? img[idx / 32] : 32'h0;
        miso[g] = w[31 - (idx % 32)];
      end
    end

    initial forever begin
      @(posedge csb[g]); #1;
      if (sclk[g] !== 1'b0) csb_bad[g]++;
    end

    // Monitor: pop and compare on every handshake; while stalled the word must hold.
    initial forever begin
      @(negedge clk);
      if (valid[g] === 1'b1) begin
        if (ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word inst=%0d actual=%h required=none", g, word[g]);
          end else begin
            chk($sformatf("word_inst%0d", g), word[g], exp_q.pop_front());
            if (exp_q.size() == 0) last_acc_cyc = cyc;
          end
          if (thru_en && have_prev) chk("word_interval", cyc - prev_acc, 32'(64 * cd_of(g)));
          have_prev = 1'b1;
          prev_acc  = cyc;
        end else if (exp_q.size() != 0) begin
          chk("word_hold", word[g], exp_q[0]);
        end
      end
    end
  end

  function automatic bit hdr_legal(logic [31:0] h);
    return (h != 0) && (h <= 32'd65535);
  endfunction

  task automatic build_img(logic [31:0] hdr, int n_pay);
    img.delete();
    img.push_back(hdr);
    for (int i = 0; i < n_pay; i++) img.push_back($urandom);
  endtask

  task automatic fixed_img();
    img.delete();
    img.push_back(32'h0000_0002);
    img.push_back(32'hDEAD_BEEF);
    img.push_back(32'h1234_5678);
  endtask

  task automatic launch(int g);
    int n;
    exp_q.delete();
    if (hdr_legal(img[0]))
      for (int i = 1; i <= int'(img[0]); i++) exp_q.push_back(img[i]);
    have_prev = 1'b0;
    @(negedge clk); start_s[g] = 1'b1;
    @(negedge clk); start_s[g] = 1'b0;
    chk("start_csb", csb[g], 0);
    chk("start_busy", busy[g], 1);
    chk("start_done", done[g], 0);
    chk("start_error", err[g], 0);
    n = 1;
    while (sclk[g] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("first_rise_cycle", n, 32'(1 + cd_of(g)));
  endtask

  task automatic finish_load(int g);
    int n = 0;
    bit legal;
    int unsigned dc;
    legal = hdr_legal(img[0]);
    while (done[g] !== 1'b1 && n < 40000) begin @(negedge clk); n++; end
    dc = cyc;
    chk("done_in_time", (n < 40000), 1);
    chk("end_done", done[g], 1);
    chk("end_error", err[g], !legal);
    chk("end_busy", busy[g], 0);
    chk("end_csb", csb[g], 1);
    chk("end_sclk", sclk[g], 0);
    chk("end_valid", valid[g], 0);
    chk("words_left", exp_q.size(), 0);
    chk("sclk_rises", rises[g], legal ? 32'(64 + 32 * int'(img[0])) : 32'd64);
    chk("cmd_addr", cmd_addr[g], {8'h03, addr_of(g)});
    chk("mosi_zero_in_read", mosi_bad[g], 0);
    chk("sclk_low_at_csb_rise", csb_bad[g], 0);
    if (legal) chk("done_after_accept", dc, last_acc_cyc + 1);
    else       chk("done_after_hdr", dc, rise64_cyc[g] + 1);
  endtask

  task automatic wait_rises(int g, int target);
    int n = 0;
    while (rises[g] < target && n < 20000) begin @(negedge clk); n++; end
    chk("rises_reached", (rises[g] >= target), 1);
  endtask

  task automatic chk_reset_vals(int g);
    chk("rst_csb", csb[g], 1);
    chk("rst_sclk", sclk[g], 0);
    chk("rst_mosi", mosi[g], 0);
    chk("rst_word", word[g], 0);
    chk("rst_valid", valid[g], 0);
    chk("rst_busy", busy[g], 0);
    chk("rst_done", done[g], 0);
    chk("rst_error", err[g], 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ready = 1'b1; start_s = '0; miso = '0;
    ready_mode = 0; thru_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rises[i] = 0; cmd_addr[i] = '0; mosi_bad[i] = 0; csb_bad[i] = 0; rise64_cyc[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk_reset_vals(0);
    chk_reset_vals(1);
    rst = 1'b0;

    // Reference image, always ready, then a restart from DONE.
    thru_en = 1'b1;
    fixed_img(); launch(0); finish_load(0);
    launch(0); finish_load(0);
    fixed_img(); launch(1); finish_load(1);

    // Backpressure: consumer stalls 200 cycles after first valid.
    thru_en = 1'b0;
    for (int g = 0; g < 2; g++) begin
      int n = 0;
      if (g == 0) fixed_img(); else build_img(32'd4, 4);
      ready_mode = 2;
      launch(g);
      while (valid[g] !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
      chk("first_valid_seen", valid[g], 1);
      repeat (200) @(negedge clk);
      chk("stall_sclk_low", sclk[g], 0);
      chk("stall_rises", rises[g], 128);
      chk("stall_word", word[g], img[1]);
      chk("stall_valid", valid[g], 1);
      chk("stall_csb", csb[g], 0);
      ready_mode = 0;
      finish_load(g);
    end

    // Illegal headers: zero, MAX_WORDS+1, large.
    for (int g = 0; g < 2; g++) begin
      build_img(32'd0, 0);        launch(g); finish_load(g);
      build_img(32'd65536, 0);    launch(g); finish_load(g);
      build_img(32'h8000_0000 | $urandom, 0); launch(g); finish_load(g);
    end

    // Reset in the middle of DATA, then a clean reload from IDLE.
    ready_mode = 0;
    build_img(32'd4, 4); launch(0);
    wait_rises(0, 106);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk_reset_vals(0);
    rst = 1'b0;
    exp_q.delete();
    build_img(32'd3, 3); launch(0); finish_load(0);

    // start_i during ADDR is ignored.
    build_img(32'd2, 2); launch(1);
    wait_rises(1, 12);
    @(negedge clk); start_s[1] = 1'b1;
    @(negedge clk); start_s[1] = 1'b0;
    chk("ignored_start_csb", csb[1], 0);
    chk("ignored_start_busy", busy[1], 1);
    finish_load(1);

    // Random images with random backpressure.
    ready_mode = 1;
    for (int k = 0; k < 8; k++) begin
      int g;
      int n;
      g = k % 2;
      n = $urandom_range(5, 1);
      build_img(32'(n), n); launch(g); finish_load(g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
